div32_seq: RTL and testbench

Sequential 32-bit unsigned restoring divider, the inverse-operation companion to the multiplier. It accepts a dividend and divisor with a start pulse and produces one quotient bit per clock. Each trial subtraction runs through the team's 32-bit carry-lookahead adder path, extended to 33 bits. It sits beside the multiplier under the same start/clear/done control scheme and reports divide-by-zero.

---
 rtl/div32_seq.sv | 128 ++++++++++++
 tb/tb_div32_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/div32_seq.sv
// Sequential 32-bit unsigned restoring divider: one quotient bit per clock,
// trial subtraction on a 33-bit carry-lookahead adder, start/clear/done control.
module div32_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_start,
    input  logic        op_clear,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        op_done,
    output logic        busy,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] q_q, q_d;
    logic [31:0] d_q, d_d;
    logic [32:0] r_q, r_d;
    logic [4:0]  count_q, count_d;
    logic        dbz_q, dbz_d;

    logic [32:0] r_shift;
    logic [31:0] q_shift;
    logic [33:0] trial;

    // Returns {carry_out, sum}; carries formed from generate/propagate terms.
    function automatic logic [33:0] cla33(input logic [32:0] a, input logic [32:0] b,
                                          input logic cin);
        logic [32:0] g;
        logic [32:0] p;
        logic [33:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        for (int i = 0; i < 33; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[33], p ^ c[32:0]};
    endfunction

    assign r_shift = {r_q[31:0], q_q[31]};
    assign q_shift = {q_q[30:0], 1'b0};
    assign trial   = cla33(r_shift, ~{1'b0, d_q}, 1'b1);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        count_d = count_q;
        dbz_d   = dbz_q;
        if (op_clear) begin
            state_d = IDLE;
            q_d     = 32'd0;
            d_d     = 32'd0;
            r_d     = 33'd0;
            count_d = 5'd0;
            dbz_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_start) begin
                        count_d = 5'd0;
                        if (divisor == 32'd0) begin
                            state_d = DONE;
                            q_d     = '1;
                            d_d     = 32'd0;
                            r_d     = {1'b0, dividend};
                            dbz_d   = 1'b1;
                        end else begin
                            state_d = EXEC;
                            q_d     = dividend;
                            d_d     = divisor;
                            r_d     = 33'd0;
                            dbz_d   = 1'b0;
                        end
                    end
                end
                EXEC: begin
                    // Carry-out of the trial subtraction means no borrow.
                    if (trial[33]) begin
                        r_d = trial[32:0];
                        q_d = q_shift | 32'd1;
                    end else begin
                        r_d = r_shift;
                        q_d = q_shift;
                    end
                    count_d = count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= 32'd0;
            d_q     <= 32'd0;
            r_q     <= 33'd0;
            count_q <= 5'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            count_q <= count_d;
            dbz_q   <= dbz_d;
        end
    end

    assign op_done     = (state_q == DONE);
    assign busy        = (state_q == EXEC);
    assign quotient    = op_done ? q_q : 32'd0;
    assign remainder   = op_done ? r_q[31:0] : 32'd0;
    assign div_by_zero = op_done & dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed vector table, abort/reset and
// ignored-control sequences, and a short random identity regression.
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_start;
    logic        op_clear;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        op_done;
    logic        busy;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } vec_t;

    vec_t vecs [0:7];

    div32_seq dut (
        .clk(clk),
        .reset(reset),
        .op_start(op_start),
        .op_clear(op_clear),
        .dividend(dividend),
        .divisor(divisor),
        .quotient(quotient),
        .remainder(remainder),
        .op_done(op_done),
        .busy(busy),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Waits (bounded) for op_done; counts busy cycles and busy/op_done overlap.
    task automatic waitDone(output int lat, output int busy_cnt, output int overlap);
        lat      = 0;
        busy_cnt = 0;
        overlap  = 0;
        while (!op_done && lat < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (busy && op_done) overlap++;
        checkOutput("done_timeout", {31'd0, lat >= 100}, 32'd0);
    endtask

    // Issues one start pulse from a negedge and waits for completion.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 output int lat, output int busy_cnt, output int overlap);
        dividend = a;
        divisor  = b;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        waitDone(lat, busy_cnt, overlap);
    endtask

    task automatic clearAndCheck(input string tag);
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
        checkOutput({tag, "_clr_done"}, {31'd0, op_done}, 32'd0);
        checkOutput({tag, "_clr_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_clr_q"}, quotient, 32'd0);
        checkOutput({tag, "_clr_r"}, remainder, 32'd0);
        checkOutput({tag, "_clr_dbz"}, {31'd0, div_by_zero}, 32'd0);
    endtask

    initial begin
        int lat, bc, ov;
        logic [31:0] a, b;
        logic [63:0] prod;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1] = '{32'hFFFFFFFF,   32'h80000001,   32'd1,          32'h7FFFFFFE,   1'b0};
        vecs[2] = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
        vecs[3] = '{32'd3,          32'hFFFFFFFF,   32'd0,          32'd3,          1'b0};
        vecs[4] = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
        vecs[5] = '{32'd1000,       32'd3,          32'd333,        32'd1,          1'b0};
        vecs[6] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[7] = '{32'd12345678,   32'd1000,       32'd12345,      32'd678,        1'b0};

        reset    = 1'b1;
        op_start = 1'b0;
        op_clear = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_done", {31'd0, op_done}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_q", quotient, 32'd0);
        checkOutput("rst_r", remainder, 32'd0);
        checkOutput("rst_dbz", {31'd0, div_by_zero}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].dvd, vecs[i].dvs, lat, bc, ov);
            checkOutput($sformatf("v%0d_lat", i), lat, vecs[i].dbz ? 32'd0 : 32'd32);
            checkOutput($sformatf("v%0d_busycyc", i), bc, vecs[i].dbz ? 32'd0 : 32'd32);
            checkOutput($sformatf("v%0d_overlap", i), ov, 32'd0);
            checkOutput($sformatf("v%0d_q", i), quotient, vecs[i].q);
            checkOutput($sformatf("v%0d_r", i), remainder, vecs[i].r);
            checkOutput($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
            if (i == 0) begin
                // Start pulse in DONE must not disturb the held result.
                dividend = 32'd9;
                divisor  = 32'd2;
                op_start = 1'b1;
                @(negedge clk);
                op_start = 1'b0;
                repeat (3) @(negedge clk);
                checkOutput("hold_done", {31'd0, op_done}, 32'd1);
                checkOutput("hold_q", quotient, 32'd14);
                checkOutput("hold_r", remainder, 32'd2);
            end
            clearAndCheck($sformatf("v%0d", i));
        end

        // Reset asserted after 10 iterations aborts the run.
        dividend = 32'd1000;
        divisor  = 32'd3;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("abort_rst_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        op_start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        op_start = 1'b0;
        checkOutput("abort_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_rst_done", {31'd0, op_done}, 32'd0);
        checkOutput("abort_rst_q", quotient, 32'd0);
        checkOutput("abort_rst_r", remainder, 32'd0);
        @(negedge clk);
        checkOutput("abort_rst_idle", {31'd0, busy | op_done}, 32'd0);

        // Same abort through op_clear.
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        repeat (10) @(negedge clk);
        clearAndCheck("abort_clr");
        @(negedge clk);
        checkOutput("abort_clr_idle", {31'd0, busy | op_done}, 32'd0);

        applyStimulus(32'd1000, 32'd3, lat, bc, ov);
        checkOutput("restart_lat", lat, 32'd32);
        checkOutput("restart_q", quotient, 32'd333);
        checkOutput("restart_r", remainder, 32'd1);
        clearAndCheck("restart");

        // Start pulse mid-EXEC is ignored.
        dividend = 32'd100;
        divisor  = 32'd7;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        repeat (4) @(negedge clk);
        dividend = 32'd77;
        divisor  = 32'd5;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        waitDone(lat, bc, ov);
        checkOutput("exec_start_lat", lat + 5, 32'd32);
        checkOutput("exec_start_q", quotient, 32'd14);
        checkOutput("exec_start_r", remainder, 32'd2);
        clearAndCheck("exec_start");

        // Simultaneous start and clear in IDLE stays IDLE.
        dividend = 32'd50;
        divisor  = 32'd0;
        op_start = 1'b1;
        op_clear = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        op_clear = 1'b0;
        checkOutput("startclr_busy", {31'd0, busy}, 32'd0);
        checkOutput("startclr_done", {31'd0, op_done}, 32'd0);

        for (int n = 0; n < 200; n++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(31, 0);
            if (b == 32'd0) b = 32'd1;
            applyStimulus(a, b, lat, bc, ov);
            prod = 64'(quotient) * 64'(b) + 64'(remainder);
            checkOutput($sformatf("rnd%0d_identity", n), {31'd0, prod == 64'(a)}, 32'd1);
            checkOutput($sformatf("rnd%0d_rem_lt", n), {31'd0, remainder < b}, 32'd1);
            op_clear = 1'b1;
            @(negedge clk);
            op_clear = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
